// File: rtl/pll_cfg_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
// Contents: video mode enum, sequencer state enum, reconfig core register
// addresses, write-sequence length, C-register field offsets, and helpers to
// build C-register words and to decode a raw mode selector.
package pll_cfg_pkg;

    typedef enum logic [1:0] {
        ModeNtsc  = 2'd0,
        ModePal   = 2'd1,
        ModeDendy = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StLockWait
    } state_e;

    // Reconfig core register map
    localparam logic [5:0] AddrMode  = 6'h00;
    localparam logic [5:0] AddrStart = 6'h02;
    localparam logic [5:0] AddrN     = 6'h03;
    localparam logic [5:0] AddrM     = 6'h04;
    localparam logic [5:0] AddrC     = 6'h05;
    localparam logic [5:0] AddrK     = 6'h07;

    localparam int unsigned NumSteps = 8;
    localparam int unsigned StepW    = 3;

    // C-register layout: [22:18] counter index, [17] odd duty, [15:8] hi, [7:0] lo
    localparam int unsigned CIdxLsb = 18;
    localparam int unsigned COddBit = 17;
    localparam int unsigned CHiLsb  = 8;
    localparam int unsigned CLoLsb  = 0;

    // N-register bypass bit
    localparam int unsigned NBypassBit = 16;

    function automatic logic [31:0] c_reg(input logic [4:0] idx, input logic odd,
                                          input logic [7:0] hi, input logic [7:0] lo);
        logic [31:0] r;
        r = '0;
        r[CIdxLsb +: 5] = idx;
        r[COddBit]      = odd;
        r[CHiLsb +: 8]  = hi;
        r[CLoLsb +: 8]  = lo;
        return r;
    endfunction

    // Encoding 3 is reserved and falls back to NTSC
    function automatic mode_e to_mode(input logic [1:0] sel);
        mode_e m;
        case (sel)
            2'd1:    m = ModePal;
            2'd2:    m = ModeDendy;
            default: m = ModeNtsc;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pll_cfg_seq_if.sv
// Avalon-MM write-only bus between the sequencer (master) and the PLL
// reconfig core (slave).
//   cfg_address     : register address, master -> slave
//   cfg_write       : write request, master -> slave
//   cfg_writedata   : write data, master -> slave
//   cfg_waitrequest : stall, slave -> master
interface pll_cfg_seq_if;
    logic [5:0]  cfg_address;
    logic        cfg_write;
    logic [31:0] cfg_writedata;
    logic        cfg_waitrequest;

    modport master (
        output cfg_address,
        output cfg_write,
        output cfg_writedata,
        input  cfg_waitrequest
    );

    modport slave (
        input  cfg_address,
        input  cfg_write,
        input  cfg_writedata,
        output cfg_waitrequest
    );
endinterface

// File: rtl/pll_cfg_rom.sv
// Combinational table of the reconfiguration write sequence.
// Ports:
//   mode      : target video mode
//   step      : sequence step 0..7
//   address   : reconfig register address for this step
//   writedata : data for this step
// Step order: mode reg, M, N, C0, C1, C2, K, start.
module pll_cfg_rom
    import pll_cfg_pkg::*;
(
    input  mode_e              mode,
    input  logic [StepW-1:0]   step,
    output logic [5:0]         address,
    output logic [31:0]        writedata
);

    localparam logic [31:0] NtscM  = 32'h0000_0404;
    localparam logic [31:0] NtscN  = 32'h0001_0000;
    localparam logic [31:0] NtscC0 = c_reg(5'd0, 1'b1, 8'd3, 8'd2);
    localparam logic [31:0] NtscC1 = c_reg(5'd1, 1'b0, 8'd5, 8'd5);
    localparam logic [31:0] NtscC2 = c_reg(5'd2, 1'b0, 8'd10, 8'd10);
    localparam logic [31:0] NtscK  = 32'h9745_CC93;

    localparam logic [31:0] PalM   = 32'h0000_0505;
    localparam logic [31:0] PalN   = 32'h0001_0000;
    localparam logic [31:0] PalC0  = c_reg(5'd0, 1'b1, 8'd4, 8'd3);
    localparam logic [31:0] PalC1  = c_reg(5'd1, 1'b0, 8'd6, 8'd6);
    localparam logic [31:0] PalC2  = c_reg(5'd2, 1'b0, 8'd12, 8'd12);
    localparam logic [31:0] PalK   = 32'h3A5C_1E70;

    // Dendy runs the N divider (bypass clear, hi=lo=1)
    localparam logic [31:0] DendyM  = 32'h0000_0606;
    localparam logic [31:0] DendyN  = 32'h0000_0101;
    localparam logic [31:0] DendyC0 = c_reg(5'd0, 1'b0, 8'd4, 8'd4);
    localparam logic [31:0] DendyC1 = c_reg(5'd1, 1'b1, 8'd8, 8'd7);
    localparam logic [31:0] DendyC2 = c_reg(5'd2, 1'b0, 8'd14, 8'd14);
    localparam logic [31:0] DendyK  = 32'h12F6_8400;

    logic [31:0] m_val, n_val, c0_val, c1_val, c2_val, k_val;

    always_comb begin
        m_val  = NtscM;
        n_val  = NtscN;
        c0_val = NtscC0;
        c1_val = NtscC1;
        c2_val = NtscC2;
        k_val  = NtscK;
        case (mode)
            ModePal: begin
                m_val  = PalM;
                n_val  = PalN;
                c0_val = PalC0;
                c1_val = PalC1;
                c2_val = PalC2;
                k_val  = PalK;
            end
            ModeDendy: begin
                m_val  = DendyM;
                n_val  = DendyN;
                c0_val = DendyC0;
                c1_val = DendyC1;
                c2_val = DendyC2;
                k_val  = DendyK;
            end
            default: ;
        endcase
    end

    always_comb begin
        address   = AddrMode;
        writedata = '0;
        unique case (step)
            3'd0: begin address = AddrMode;  writedata = '0;     end
            3'd1: begin address = AddrM;     writedata = m_val;  end
            3'd2: begin address = AddrN;     writedata = n_val;  end
            3'd3: begin address = AddrC;     writedata = c0_val; end
            3'd4: begin address = AddrC;     writedata = c1_val; end
            3'd5: begin address = AddrC;     writedata = c2_val; end
            3'd6: begin address = AddrK;     writedata = k_val;  end
            3'd7: begin address = AddrStart; writedata = '0;     end
        endcase
    end

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer (Avalon-MM initiator).
// On a mode change request, writes the fixed 8-step sequence to the PLL
// reconfig core, then waits for LOCK_STABLE consecutive synchronized lock
// samples before pulsing done and updating cur_mode.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   mode_req   : one-cycle request strobe
//   mode_sel   : target mode (0 NTSC, 1 PAL, 2 Dendy, 3 -> NTSC)
//   pll_locked : asynchronous PLL lock, 2-FF synchronized here
//   cfg        : Avalon-MM master to the reconfig core
//   busy       : sequence in progress
//   done       : one-cycle pulse on completion (or same-mode request)
//   err        : one-cycle pulse on lock timeout
//   cur_mode   : mode currently programmed
// Optional feature: define PLL_CFG_LOCK_TIMEOUT_EN to enable the lock timeout
// (LOCK_TIMEOUT cycles from start-write acceptance); otherwise err is 0 and
// LOCK_WAIT waits indefinitely.
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_req,
    input  logic [1:0]        mode_sel,
    input  logic              pll_locked,
    pll_cfg_seq_if.master     cfg,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        cur_mode
);

    localparam int unsigned    LockW    = $clog2(LOCK_STABLE + 1);
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_STABLE - 1);
    localparam logic [StepW-1:0] StepLast = StepW'(NumSteps - 1);

    state_e             state_q, state_d;
    logic [StepW-1:0]   step_q, step_d;
    mode_e              tgt_q, tgt_d;
    mode_e              cur_q, cur_d;
    logic               pend_v_q, pend_v_d;
    mode_e              pend_mode_q, pend_mode_d;
    logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
    logic               done_q, done_d;
    logic               sync1_q, sync2_q;

    logic               eff_req;
    mode_e              eff_mode;
    logic [5:0]         rom_address;
    logic [31:0]        rom_writedata;

`ifdef PLL_CFG_LOCK_TIMEOUT_EN
    localparam logic [20:0] TmoLast = 21'(LOCK_TIMEOUT - 1);
    logic [20:0]        tmo_q, tmo_d;
    logic               err_q, err_d;
`else
    logic               unused_tmo;
    assign unused_tmo = ^LOCK_TIMEOUT;
`endif

    // A fresh strobe overrides anything pending (last request wins)
    assign eff_req  = mode_req | pend_v_q;
    assign eff_mode = mode_req ? to_mode(mode_sel) : pend_mode_q;

    pll_cfg_rom u_rom (
        .mode      (tgt_q),
        .step      (step_q),
        .address   (rom_address),
        .writedata (rom_writedata)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        tgt_d       = tgt_q;
        cur_d       = cur_q;
        pend_v_d    = pend_v_q;
        pend_mode_d = pend_mode_q;
        lock_cnt_d  = lock_cnt_q;
        done_d      = 1'b0;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = 1'b0;
`endif

        // Requests while busy are held one-deep for the next IDLE cycle
        if (state_q != StIdle && mode_req) begin
            pend_v_d    = 1'b1;
            pend_mode_d = to_mode(mode_sel);
        end

        unique case (state_q)
            StIdle: begin
                if (eff_req) begin
                    pend_v_d = 1'b0;
                    if (eff_mode == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StWrite;
                        step_d  = '0;
                        tgt_d   = eff_mode;
                    end
                end
            end
            StWrite: begin
                if (!cfg.cfg_waitrequest) begin
                    if (step_q == StepLast) begin
                        state_d    = StLockWait;
                        lock_cnt_d = '0;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
                        tmo_d      = '0;
`endif
                    end else begin
                        step_d = step_q + StepW'(1);
                    end
                end
            end
            StLockWait: begin
                if (!sync2_q) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LockLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    cur_d   = tgt_q;
                end else begin
                    lock_cnt_d = lock_cnt_q + LockW'(1);
                end
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
                tmo_d = tmo_q + 21'd1;
                // Lock completing in the same cycle takes precedence
                if (state_d == StLockWait && tmo_q == TmoLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            tgt_q       <= ModeNtsc;
            cur_q       <= ModeNtsc;
            pend_v_q    <= 1'b0;
            pend_mode_q <= ModeNtsc;
            lock_cnt_q  <= '0;
            done_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            tgt_q       <= tgt_d;
            cur_q       <= cur_d;
            pend_v_q    <= pend_v_d;
            pend_mode_q <= pend_mode_d;
            lock_cnt_q  <= lock_cnt_d;
            done_q      <= done_d;
            sync1_q     <= pll_locked;
            sync2_q     <= sync1_q;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    // Address/data decoded from registered state, so they cannot move while stalled
    assign cfg.cfg_write     = (state_q == StWrite);
    assign cfg.cfg_address   = cfg.cfg_write ? rom_address : '0;
    assign cfg.cfg_writedata = cfg.cfg_write ? rom_writedata : '0;

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign cur_mode = cur_q;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Scoreboard bench for pll_cfg_seq: stimulus pushes expected writes and
// expected done/err events; a monitor on the falling edge compares them.
module tb_pll_cfg_seq;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [1:0] mode;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        mode_req;
    logic [1:0]  mode_sel;
    logic        pll_locked;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  cur_mode;
    logic        wr_stall;

    int          checks;
    int          errors;
    int          cyc;
    int          req_cyc;
    int          last_pop_cyc;
    int          stall_left;
    bit          mon_en;

    wr_t         wq[$];
    ev_t         evq[$];

    pll_cfg_seq_if ifc ();

    assign ifc.cfg_waitrequest = wr_stall;

    pll_cfg_seq #(
        .LOCK_STABLE  (16),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_req   (mode_req),
        .mode_sel   (mode_sel),
        .pll_locked (pll_locked),
        .cfg        (ifc),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_mode   (cur_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Hand-computed sequences: mode, M, N, C0, C1, C2, K, start
    function automatic logic [31:0] exp_data(input int m, input int s);
        logic [31:0] t [8];
        case (m)
            1: t = '{32'h0, 32'h0000_0505, 32'h0001_0000, 32'h0002_0403,
                     32'h0004_0606, 32'h0008_0C0C, 32'h3A5C_1E70, 32'h0};
            2: t = '{32'h0, 32'h0000_0606, 32'h0000_0101, 32'h0000_0404,
                     32'h0006_0807, 32'h0008_0E0E, 32'h12F6_8400, 32'h0};
            default: t = '{32'h0, 32'h0000_0404, 32'h0001_0000, 32'h0002_0302,
                           32'h0004_0505, 32'h0008_0A0A, 32'h9745_CC93, 32'h0};
        endcase
        return t[s];
    endfunction

    task automatic push_writes(input int m);
        logic [5:0] a [8];
        a = '{6'h00, 6'h04, 6'h03, 6'h05, 6'h05, 6'h05, 6'h07, 6'h02};
        for (int s = 0; s < 8; s++) begin
            wr_t w;
            w.addr = a[s];
            w.data = exp_data(m, s);
            wq.push_back(w);
        end
    endtask

    task automatic push_ev(input bit is_err, input int c, input logic [1:0] m);
        ev_t e;
        e.is_err = is_err;
        e.cyc    = c;
        e.mode   = m;
        evq.push_back(e);
    endtask

    task automatic req(input logic [1:0] m);
        @(posedge clk); #1;
        mode_req = 1'b1;
        mode_sel = m;
        req_cyc  = cyc;
        @(posedge clk); #1;
        mode_req = 1'b0;
    endtask

    task automatic wait_wq(input int n, input int budget, input string what);
        int k;
        k = 0;
        while (wq.size() > n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (wq.size() > n) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d writes outstanding, required %0d", what,
                     wq.size(), n);
        end
    endtask

    task automatic wait_all(input int budget, input string what);
        int k;
        k = 0;
        while ((wq.size() != 0 || evq.size() != 0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (wq.size() != 0 || evq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d writes and %0d events outstanding, required 0",
                     what, wq.size(), evq.size());
        end
    endtask

    // Raise lock now and expect done 18 cycles later (16 stable + 2 sync)
    task automatic raise_lock(input logic [1:0] m);
        @(posedge clk); #1;
        pll_locked = 1'b1;
        push_ev(1'b0, cyc + 18, m);
    endtask

    task automatic drop_lock();
        pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_busy_start(input string name);
        @(negedge clk);
        check({name, "_busy"}, {31'b0, busy}, 32'd1);
        check({name, "_write"}, {31'b0, ifc.cfg_write}, 32'd1);
    endtask

    // Slave model: stall the M write for stall_left cycles
    always @(posedge clk) begin
        #1;
        if (ifc.cfg_write && ifc.cfg_address == 6'h04 && stall_left > 0) begin
            wr_stall = 1'b1;
            stall_left--;
        end else begin
            wr_stall = 1'b0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (ifc.cfg_write === 1'b1) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write",
                             ifc.cfg_address, ifc.cfg_writedata);
                end else begin
                    check("wr_addr", {26'b0, ifc.cfg_address}, {26'b0, wq[0].addr});
                    check("wr_data", ifc.cfg_writedata, wq[0].data);
                    if (!ifc.cfg_waitrequest) begin
                        void'(wq.pop_front());
                        last_pop_cyc = cyc;
                    end
                end
            end
            if (done === 1'b1 || err === 1'b1) begin
                if (evq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: done=%0b err=%0b, required none", done, err);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    check("ev_done", {31'b0, done}, {31'b0, !e.is_err});
                    check("ev_err", {31'b0, err}, {31'b0, e.is_err});
                    check("ev_cycle", cyc, e.cyc);
                    check("ev_cur_mode", {30'b0, cur_mode}, {30'b0, e.mode});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        req_cyc      = 0;
        last_pop_cyc = 0;
        stall_left   = 0;
        mon_en       = 1'b0;
        wr_stall     = 1'b0;
        rst          = 1'b1;
        mode_req     = 1'b0;
        mode_sel     = 2'd0;
        pll_locked   = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_write", {31'b0, ifc.cfg_write}, 32'd0);
        check("rst_addr", {26'b0, ifc.cfg_address}, 32'd0);
        check("rst_data", ifc.cfg_writedata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_cur_mode", {30'b0, cur_mode}, 32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Same-mode requests: NTSC, then reserved code 3 (treated as NTSC)
        @(posedge clk); #1;
        mode_req = 1'b1;
        mode_sel = 2'd0;
        push_ev(1'b0, cyc + 1, 2'd0);
        @(posedge clk); #1;
        mode_req = 1'b0;
        wait_all(10, "same_ntsc");
        @(posedge clk); #1;
        mode_req = 1'b1;
        mode_sel = 2'd3;
        push_ev(1'b0, cyc + 1, 2'd0);
        @(posedge clk); #1;
        mode_req = 1'b0;
        wait_all(10, "same_rsvd");

        // NTSC -> PAL, no stalls: 8 back-to-back writes
        push_writes(1);
        req(2'd1);
        check_busy_start("pal");
        wait_wq(0, 50, "pal_writes");
        check("pal_consecutive", last_pop_cyc, req_cyc + 8);
        raise_lock(2'd1);
        wait_all(60, "pal_lock");
        @(negedge clk);
        check("pal_cur_mode", {30'b0, cur_mode}, 32'd1);
        check("pal_busy_after", {31'b0, busy}, 32'd0);

        // PAL -> NTSC with M write stalled 5 cycles
        drop_lock();
        push_writes(0);
        stall_left = 5;
        req(2'd0);
        check_busy_start("stall");
        wait_wq(0, 50, "stall_writes");
        check("stall_span", last_pop_cyc, req_cyc + 13);
        raise_lock(2'd0);
        wait_all(60, "stall_lock");

        // NTSC -> PAL, with PAL then Dendy requested while busy
        drop_lock();
        push_writes(1);
        push_writes(2);
        req(2'd1);
        check_busy_start("pend");
        req(2'd1);
        req(2'd2);
        wait_wq(8, 50, "pend_first_writes");
        raise_lock(2'd1);
        begin
            int k;
            k = 0;
            while (evq.size() != 0 && k < 60) begin
                @(posedge clk); #1;
                k++;
            end
        end
        pll_locked = 1'b0;
        wait_wq(0, 50, "pend_second_writes");
        raise_lock(2'd2);
        wait_all(60, "pend_lock");
        @(negedge clk);
        check("pend_cur_mode", {30'b0, cur_mode}, 32'd2);

        // Dendy -> NTSC with a one-cycle lock glitch restarting the count
        drop_lock();
        push_writes(0);
        req(2'd0);
        wait_wq(0, 50, "glitch_writes");
        @(posedge clk); #1;
        pll_locked = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        pll_locked = 1'b0;
        @(posedge clk); #1;
        pll_locked = 1'b1;
        push_ev(1'b0, cyc + 18, 2'd0);
        wait_all(60, "glitch_lock");

        // Reset during the C1 write, then a full restart
        drop_lock();
        push_writes(1);
        req(2'd1);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 40 && !hit; i++) begin
                @(posedge clk); #2;
                if (ifc.cfg_write && ifc.cfg_address == 6'h05 && wq.size() == 4) hit = 1'b1;
            end
            if (!hit) begin
                checks++;
                errors++;
                $display("FAIL rst_mid_find_c1: C1 write not seen, required within 40 cycles");
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wq.delete();
        @(negedge clk);
        check("rstmid_write", {31'b0, ifc.cfg_write}, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_cur_mode", {30'b0, cur_mode}, 32'd0);
        push_writes(1);
        req(2'd1);
        check_busy_start("restart");
        wait_wq(0, 50, "restart_writes");
        raise_lock(2'd1);
        wait_all(60, "restart_lock");

`ifdef PLL_CFG_LOCK_TIMEOUT_EN
        // Lock never arrives: err after 100 cycles, cur_mode stays PAL
        drop_lock();
        push_writes(0);
        req(2'd0);
        wait_wq(0, 50, "tmo_writes");
        push_ev(1'b1, last_pop_cyc + 101, 2'd1);
        wait_all(150, "tmo_err");
        @(negedge clk);
        check("tmo_cur_mode", {30'b0, cur_mode}, 32'd1);
        check("tmo_busy", {31'b0, busy}, 32'd0);
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("end_wq_empty", wq.size(), 32'd0);
        check("end_evq_empty", evq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
